// File: rtl/dp_pkg.sv
// Shared opcode and sequencer definitions for the single-bus execution datapath.
// Widths here are independent of the data WIDTH parameter.
package dp_pkg;

  localparam int OP_W  = 4;
  localparam int FSM_W = 2;

  typedef enum logic [OP_W-1:0] {
    OP_ADD   = 4'h0,
    OP_SUB   = 4'h1,
    OP_AND   = 4'h2,
    OP_OR    = 4'h3,
    OP_XOR   = 4'h4,
    OP_SHL   = 4'h5,
    OP_SHR   = 4'h6,
    OP_SHRA  = 4'h7,
    OP_ROL   = 4'h8,
    OP_ROR   = 4'h9,
    OP_MUL   = 4'hA,
    OP_NEG   = 4'hB,
    OP_NOT   = 4'hC,
    OP_PASSB = 4'hD,
    OP_RSV_E = 4'hE,
    OP_RSV_F = 4'hF
  } op_e;

  typedef enum logic [FSM_W-1:0] {
    ST_IDLE = 2'd0,
    ST_TA   = 2'd1,
    ST_TB   = 2'd2,
    ST_WB   = 2'd3
  } state_e;

  // Reserved opcodes run the full sequence but never touch the register file.
  function automatic logic op_writes_rc(input logic [OP_W-1:0] op);
    return (op != OP_RSV_E) && (op != OP_RSV_F);
  endfunction

endpackage

// File: rtl/dp_alu.sv
// Combinational ALU: (a, b, op) -> {hi, lo}; zero latency, no flow control.
// hi/hi_we are only meaningful for MUL; reserved opcodes produce lo = 0.
module dp_alu
  import dp_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [OP_W-1:0]  i_op,
  output logic [WIDTH-1:0] o_lo,
  output logic [WIDTH-1:0] o_hi,
  output logic             o_hi_we
);

  localparam int SHW = $clog2(WIDTH);

  logic [SHW-1:0]          w_sh;
  logic [2*WIDTH-1:0]      w_rol;
  logic [2*WIDTH-1:0]      w_ror;
  logic signed [2*WIDTH-1:0] w_sa;
  logic signed [2*WIDTH-1:0] w_sb;
  logic signed [2*WIDTH-1:0] w_prod;

  assign w_sh   = i_b[SHW-1:0];
  // Rotates via a doubled operand so a zero amount needs no special case.
  assign w_rol  = {i_a, i_a} << w_sh;
  assign w_ror  = {i_a, i_a} >> w_sh;
  assign w_sa   = {{WIDTH{i_a[WIDTH-1]}}, i_a};
  assign w_sb   = {{WIDTH{i_b[WIDTH-1]}}, i_b};
  assign w_prod = w_sa * w_sb;

  always_comb begin
    o_lo    = '0;
    o_hi    = '0;
    o_hi_we = 1'b0;
    case (i_op)
      OP_ADD:   o_lo = i_a + i_b;
      OP_SUB:   o_lo = i_a - i_b;
      OP_AND:   o_lo = i_a & i_b;
      OP_OR:    o_lo = i_a | i_b;
      OP_XOR:   o_lo = i_a ^ i_b;
      OP_SHL:   o_lo = i_a << w_sh;
      OP_SHR:   o_lo = i_a >> w_sh;
      OP_SHRA:  o_lo = WIDTH'($signed(i_a) >>> w_sh);
      OP_ROL:   o_lo = w_rol[2*WIDTH-1:WIDTH];
      OP_ROR:   o_lo = w_ror[WIDTH-1:0];
      OP_MUL: begin
        o_lo    = w_prod[WIDTH-1:0];
        o_hi    = w_prod[2*WIDTH-1:WIDTH];
        o_hi_we = 1'b1;
      end
      OP_NEG:   o_lo = '0 - i_b;
      OP_NOT:   o_lo = ~i_b;
      OP_PASSB: o_lo = i_b;
      default:  o_lo = '0;
    endcase
  end

endmodule

// File: rtl/param_bus_datapath.sv
// Single-bus datapath with 3-step sequencer (A->Y, B->ALU->Z, Z->Rc): done 3 cycles after accept.
// start and ld_en are ignored while busy; R0_ZERO_EN makes R0 a hard-wired zero.
module param_bus_datapath
  import dp_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int NUM_REGS = 16,
  parameter int REG_AW   = $clog2(NUM_REGS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [OP_W-1:0]   op,
  input  logic [REG_AW-1:0] ra,
  input  logic [REG_AW-1:0] rb,
  input  logic [REG_AW-1:0] rc,
  input  logic [WIDTH-1:0]  imm,
  input  logic              use_imm,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  result,
  output logic [WIDTH-1:0]  hi_out,
  output logic              flag_zero,
  output logic              flag_neg,
  input  logic              ld_en,
  input  logic [REG_AW-1:0] ld_addr,
  input  logic [WIDTH-1:0]  ld_data,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [WIDTH-1:0]  dbg_data
);

  state_e            r_state;
  state_e            w_next;
  logic [WIDTH-1:0]  r_regs [NUM_REGS];
  logic [OP_W-1:0]   r_op;
  logic [REG_AW-1:0] r_ra;
  logic [REG_AW-1:0] r_rb;
  logic [REG_AW-1:0] r_rc;
  logic [WIDTH-1:0]  r_imm;
  logic              r_use_imm;
  logic [WIDTH-1:0]  r_y;
  logic [WIDTH-1:0]  r_z;
  logic [WIDTH-1:0]  r_hi;
  logic              r_zero;
  logic              r_neg;

  logic              w_accept;
  logic              w_wb_we;
  logic              w_ld_we;
  logic [WIDTH-1:0]  w_bus;
  logic [WIDTH-1:0]  w_alu_lo;
  logic [WIDTH-1:0]  w_alu_hi;
  logic              w_alu_hi_we;

  function automatic logic [WIDTH-1:0] f_rd(input logic [REG_AW-1:0] idx);
`ifdef R0_ZERO_EN
    return (idx == '0) ? '0 : r_regs[idx];
`else
    return r_regs[idx];
`endif
  endfunction

  assign w_accept = (r_state == ST_IDLE) && start;

`ifdef R0_ZERO_EN
  assign w_wb_we = (r_state == ST_WB) && op_writes_rc(r_op) && (r_rc != '0);
  assign w_ld_we = (r_state == ST_IDLE) && ld_en && (ld_addr != '0);
`else
  assign w_wb_we = (r_state == ST_WB) && op_writes_rc(r_op);
  assign w_ld_we = (r_state == ST_IDLE) && ld_en;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (start) w_next = ST_TA;
      ST_TA:   w_next = ST_TB;
      ST_TB:   w_next = ST_WB;
      ST_WB:   w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // The one shared bus: who drives it is purely a function of the sequencer step.
  always_comb begin
    w_bus = '0;
    case (r_state)
      ST_TA:   w_bus = f_rd(r_ra);
      ST_TB:   w_bus = r_use_imm ? r_imm : f_rd(r_rb);
      ST_WB:   w_bus = r_z;
      default: w_bus = '0;
    endcase
  end

  dp_alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .i_a     (r_y),
    .i_b     (w_bus),
    .i_op    (r_op),
    .o_lo    (w_alu_lo),
    .o_hi    (w_alu_hi),
    .o_hi_we (w_alu_hi_we)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (w_wb_we) begin
      r_regs[r_rc] <= w_bus;
    end else if (w_ld_we) begin
      r_regs[ld_addr] <= ld_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_op      <= '0;
      r_ra      <= '0;
      r_rb      <= '0;
      r_rc      <= '0;
      r_imm     <= '0;
      r_use_imm <= 1'b0;
      r_y       <= '0;
      r_z       <= '0;
      r_hi      <= '0;
      r_zero    <= 1'b0;
      r_neg     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op      <= op;
        r_ra      <= ra;
        r_rb      <= rb;
        r_rc      <= rc;
        r_imm     <= imm;
        r_use_imm <= use_imm;
      end
      if (r_state == ST_TA) r_y <= w_bus;
      // Z and flags settle at the end of T_B so they are stable for the whole done cycle.
      if (r_state == ST_TB) begin
        r_z    <= w_alu_lo;
        r_zero <= (w_alu_lo == '0);
        r_neg  <= w_alu_lo[WIDTH-1];
        if (w_alu_hi_we) r_hi <= w_alu_hi;
      end
    end
  end

  assign busy      = (r_state != ST_IDLE);
  assign done      = (r_state == ST_WB);
  assign result    = r_z;
  assign hi_out    = r_hi;
  assign flag_zero = r_zero;
  assign flag_neg  = r_neg;
  assign dbg_data  = f_rd(dbg_addr);

endmodule
